button_encoder: RTL and testbench

//  Player-input front end of the Genius game: samples the four raw colour buttons,

---
 rtl/genius_pkg.sv | 47 ++++
 rtl/btn_debounce.sv | 70 +++++++
 rtl/button_encoder.sv | 146 ++++++++++++++
 tb/tb_button_encoder.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/genius_pkg.sv
// -----------------------------------------------------------------------------
// genius_pkg
//   Types and constants shared by the Genius game blocks.
//   - color_t       : colour code carried from the button front end to the game
//                     controller and decoded by the LED driver
//                     (0 green, 1 blue, 2 red, 3 yellow).
//   - NUM_BUTTONS   : number of colour buttons / LEDs on the board.
//   - press_state_t : state of the button-press acceptance FSM.
//   - encode_onehot : one-hot button vector -> colour code.
//   - multi_hot     : true when two or more bits of a vector are set.
// -----------------------------------------------------------------------------
package genius_pkg;

  typedef enum logic [1:0] {
    GREEN  = 2'd0,
    BLUE   = 2'd1,
    RED    = 2'd2,
    YELLOW = 2'd3
  } color_t;

  localparam int NUM_BUTTONS = 4;

  // IDLE         : waiting for a fresh press.
  // WAIT_RELEASE : a press (or chord) was seen; nothing new is accepted until
  //                every button is back up.
  typedef enum logic [0:0] {
    ST_IDLE         = 1'b0,
    ST_WAIT_RELEASE = 1'b1
  } press_state_t;

  // Bit i of the vector is button i in colour-code order, so the position of
  // the set bit is the code itself. Callers guarantee the vector is one-hot.
  function automatic color_t encode_onehot(input logic [NUM_BUTTONS-1:0] onehot);
    color_t code;
    code = GREEN;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (onehot[i]) code = color_t'(i[1:0]);
    end
    return code;
  endfunction

  // Clearing the lowest set bit leaves something only if a second bit was set.
  function automatic logic multi_hot(input logic [NUM_BUTTONS-1:0] vec);
    return (vec & (vec - 1'b1)) != '0;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//   One raw push button -> clean, clock-synchronous level plus a press pulse.
//   The raw pin is brought into the clock domain by a two-flop synchroniser.
//   A counter measures how long the synchronised level has disagreed with the
//   debounced level; once the disagreement has lasted DEBOUNCE_CYCLES+1
//   consecutive samples the debounced level flips. Any agreement in between
//   restarts the count, so bounces and glitches shorter than DEBOUNCE_CYCLES
//   never appear on `level`.
//
// Parameters
//   DEBOUNCE_CYCLES  stable cycles required to accept a level change (>= 2)
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   btn_raw  in   raw button pin, asynchronous to clk, active-high
//   level    out  debounced button level (registered)
//   rise     out  high for the one cycle in which `level` has just gone 0 -> 1
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic             sync_meta;   // first synchroniser stage, may go metastable
  logic             sync_q;      // second stage, safe to use in logic
  logic [CNT_W-1:0] cnt;         // cycles of disagreement so far
  logic             level_prev;  // debounced level one cycle ago

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the values from before the clock edge and the order of
  // statements inside the block does not change the hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta  <= 1'b0;
      sync_q     <= 1'b0;
      cnt        <= '0;
      level      <= 1'b0;
      level_prev <= 1'b0;
    end else begin
      sync_meta  <= btn_raw;
      sync_q     <= sync_meta;
      level_prev <= level;

      if (sync_q == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        // Disagreement has persisted long enough: accept the new level.
        level <= ~level;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Edge detect against the registered previous level; only press (0 -> 1)
  // edges matter to the game, releases are tracked through `level` itself.
  assign rise = level & ~level_prev;

endmodule

// File: rtl/button_encoder.sv
// -----------------------------------------------------------------------------
// button_encoder
//   Player-input front end of the Genius game. The four raw colour buttons
//   are synchronised and debounced individually; an acceptance FSM turns a
//   single clean press into a colour code, which is then offered to the game
//   controller through a one-entry valid/ready buffer.
//
//   Acceptance rules
//   - IDLE: exactly one button goes down while all others are up -> the
//     press is encoded and loaded into the buffer.
//     Two or more buttons going down in the same cycle, or one going down
//     while another is already held -> press_error pulse, nothing loaded.
//     In both cases the FSM moves to WAIT_RELEASE.
//   - WAIT_RELEASE: further presses are ignored silently; once every
//     debounced level is low the FSM returns to IDLE.
//
//   Output buffer
//   - A load sets color_valid and writes color_data.
//   - color_valid && color_ready transfers the entry; color_valid drops on
//     the next edge unless a load happens on that same edge, in which case
//     the new code replaces the old one and color_valid stays high.
//   - A load while the entry is held (color_valid && !color_ready) is
//     dropped: the buffered code is kept and overrun pulses for one cycle.
//
//   Latency: a raw level stable from sampling edge N gives color_valid at
//   edge N + DEBOUNCE_CYCLES + 3 (2 synchroniser + debounce + 1 FSM/load).
//
// Parameters
//   DATA_WIDTH       width of color_data (>= 2); code in [1:0], rest zero
//   DEBOUNCE_CYCLES  stable cycles required to accept a level change (>= 2)
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   btn_green    in   raw button, asynchronous, active-high
//   btn_blue     in   raw button, asynchronous, active-high
//   btn_red      in   raw button, asynchronous, active-high
//   btn_yellow   in   raw button, asynchronous, active-high
//   color_valid  out  color_data holds an unconsumed press
//   color_ready  in   consumer accepts color_data this cycle
//   color_data   out  colour code of the press
//   press_error  out  1-cycle pulse: two or more buttons pressed together
//   overrun      out  1-cycle pulse: press dropped because the buffer was full
// -----------------------------------------------------------------------------
module button_encoder
  import genius_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  btn_green,
  input  logic                  btn_blue,
  input  logic                  btn_red,
  input  logic                  btn_yellow,
  output logic                  color_valid,
  input  logic                  color_ready,
  output logic [DATA_WIDTH-1:0] color_data,
  output logic                  press_error,
  output logic                  overrun
);

  // Buttons gathered in colour-code order so bit index == colour code.
  logic [NUM_BUTTONS-1:0] btn_raw;
  logic [NUM_BUTTONS-1:0] level;
  logic [NUM_BUTTONS-1:0] rise;

  assign btn_raw = {btn_yellow, btn_red, btn_blue, btn_green};

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .rst_n   (rst_n),
      .btn_raw (btn_raw[g]),
      .level   (level[g]),
      .rise    (rise[g])
    );
  end

  press_state_t          state;
  logic                  any_rise;
  logic                  clean_press;
  logic                  load_req;
  color_t                press_code;
  logic [DATA_WIDTH-1:0] press_word;

  // A clean press is a single new edge with no other button already held:
  // `level & ~rise` is the set of buttons that were down before this cycle.
  // NOTE: every signal assigned in this always_comb gets a default first, so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    any_rise    = |rise;
    clean_press = any_rise && !multi_hot(rise) && ((level & ~rise) == '0);
    load_req    = (state == ST_IDLE) && clean_press;
    press_code  = encode_onehot(rise);
    press_word  = '0;
    press_word[1:0] = press_code;
  end

  // NOTE: reset is asynchronous on assertion; rst_n is released synchronously
  // upstream, so all state leaves reset on the same clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      color_valid <= 1'b0;
      color_data  <= '0;
      press_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      // Status outputs are single-cycle pulses unless set again below.
      press_error <= 1'b0;
      overrun     <= 1'b0;

      // Press acceptance.
      case (state)
        ST_IDLE: begin
          if (any_rise) begin
            state <= ST_WAIT_RELEASE;
            if (!clean_press) press_error <= 1'b1;
          end
        end
        ST_WAIT_RELEASE: begin
          if (level == '0) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // Single-entry output buffer. A load on the same edge as a transfer
      // simply overwrites the entry, keeping color_valid high.
      if (load_req) begin
        if (color_valid && !color_ready) begin
          overrun <= 1'b1;
        end else begin
          color_valid <= 1'b1;
          color_data  <= press_word;
        end
      end else if (color_valid && color_ready) begin
        color_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_button_encoder.sv
// -----------------------------------------------------------------------------
// tb_button_encoder
//   Directed scenarios followed by randomized button activity. A reference
//   model, advanced once per clock, predicts every transfer, press_error and
//   overrun event (with the cycle it must be observed in) and pushes it into
//   a queue; an independent monitor pops and compares whenever the DUT shows
//   one of those events, and flags events the DUT shows but the model did not
//   predict (and vice versa).
// -----------------------------------------------------------------------------
module tb_button_encoder;
  import genius_pkg::*;

  localparam int DW = 8;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    btn = '0;          // {yellow, red, blue, green}
  logic          color_ready = 1'b1;
  logic          color_valid;
  logic [DW-1:0] color_data;
  logic          press_error;
  logic          overrun;

  button_encoder #(
    .DATA_WIDTH      (DW),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_green   (btn[0]),
    .btn_blue    (btn[1]),
    .btn_red     (btn[2]),
    .btn_yellow  (btn[3]),
    .color_valid (color_valid),
    .color_ready (color_ready),
    .color_data  (color_data),
    .press_error (press_error),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;   // number of rising edges so far
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. At the falling edge before rising edge k+1 the inputs
  // for that edge are stable, so the model predicts what edge k+1 does.
  // Debounce is described on the raw sample history: a button's clean level
  // changes once the DB+1 most recent synchronised samples (raw samples
  // delayed by two edges) all differ from it.
  // ---------------------------------------------------------------------------
  typedef struct {
    int stamp;   // cycle (value of cyc) in which the monitor must see it
    int data;
  } ev_t;

  ev_t xfer_q[$];
  ev_t err_q[$];
  ev_t ovr_q[$];

  logic [DB+2:0] hist [4];   // bit i = raw sample taken i edges before edge k+1
  logic [3:0]    m_lvl;
  logic [3:0]    m_lvl_prev;
  bit            m_waiting;
  bit            m_buf_valid;
  int            m_buf_data;

  task automatic model_reset();
    for (int b = 0; b < 4; b++) hist[b] = '0;
    m_lvl       = '0;
    m_lvl_prev  = '0;
    m_waiting   = 1'b0;
    m_buf_valid = 1'b0;
    m_buf_data  = 0;
    xfer_q.delete();
    err_q.delete();
    ovr_q.delete();
  endtask

  task automatic model_step();
    logic [3:0]  press;
    logic [DB:0] window;
    bit          load;
    int          code;
    ev_t         e;

    press = m_lvl & ~m_lvl_prev;
    load  = 1'b0;
    code  = 0;

    // Game rules: one clean press accepted, chords flagged, then wait for
    // every button to be released.
    if (!m_waiting) begin
      if (press != 0) begin
        m_waiting = 1'b1;
        if ($countones(press) == 1 && (m_lvl & ~press) == 0) begin
          load = 1'b1;
          for (int i = 0; i < 4; i++) if (press[i]) code = i;
        end else begin
          e.stamp = cyc + 1; e.data = 0;
          err_q.push_back(e);
        end
      end
    end else if (m_lvl == 0) begin
      m_waiting = 1'b0;
    end

    // Output buffer: the transfer is visible in the current cycle.
    if (m_buf_valid && color_ready) begin
      e.stamp = cyc; e.data = m_buf_data;
      xfer_q.push_back(e);
    end
    if (load) begin
      if (m_buf_valid && !color_ready) begin
        e.stamp = cyc + 1; e.data = 0;
        ovr_q.push_back(e);
      end else begin
        m_buf_valid = 1'b1;
        m_buf_data  = code;
      end
    end else if (m_buf_valid && color_ready) begin
      m_buf_valid = 1'b0;
    end

    // Clean levels after edge k+1.
    m_lvl_prev = m_lvl;
    for (int b = 0; b < 4; b++) begin
      hist[b] = {hist[b][DB+1:0], btn[b]};
      window  = hist[b][DB+2:2];
      if (m_lvl[b] ? (window == '0) : (window == '1)) m_lvl[b] = ~m_lvl[b];
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard.
  // ---------------------------------------------------------------------------
  int xfer_seen = 0;
  int err_seen  = 0;
  int ovr_seen  = 0;
  int last_data = -1;

  always @(negedge clk) begin
    bit dut_ev, exp_ev;
    #1;
    if (rst_n) begin
      dut_ev = color_valid && color_ready;
      exp_ev = xfer_q.size() > 0 && xfer_q[0].stamp == cyc;
      check("transfer_event", dut_ev, exp_ev);
      if (dut_ev && exp_ev) check("transfer_data", color_data, xfer_q[0].data);
      if (exp_ev) void'(xfer_q.pop_front());
      if (dut_ev) begin
        xfer_seen++;
        last_data = int'(color_data);
      end

      dut_ev = press_error;
      exp_ev = err_q.size() > 0 && err_q[0].stamp == cyc;
      check("press_error_event", dut_ev, exp_ev);
      if (exp_ev) void'(err_q.pop_front());
      if (dut_ev) err_seen++;

      dut_ev = overrun;
      exp_ev = ovr_q.size() > 0 && ovr_q[0].stamp == cyc;
      check("overrun_event", dut_ev, exp_ev);
      if (exp_ev) void'(ovr_q.pop_front());
      if (dut_ev) ovr_seen++;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus. Inputs change 1 time unit after a rising edge.
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_edge(input int target);
    while (cyc < target) tick(1);
  endtask

  task automatic press(input int b, input int hold, input int gap);
    btn[b] = 1'b1;
    tick(hold);
    btn[b] = 1'b0;
    tick(gap);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_valid"}, color_valid, 0);
    check({tag, "_data"},  color_data,  0);
    check({tag, "_error"}, press_error, 0);
    check({tag, "_overrun"}, overrun,   0);
  endtask

  int c0, n_edge, x0, e0, o0;

  initial begin
    // 1: reset with buttons idle.
    tick(3);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    tick(2);

    // 2: red held 12 cycles, ready=1 -> valid exactly at edge N+DB+3.
    c0 = cyc;
    n_edge = c0 + 1;
    btn[2] = 1'b1;
    wait_edge(n_edge + DB + 2);
    @(negedge clk); #2;
    check("latency_valid_early", color_valid, 0);
    wait_edge(n_edge + DB + 3);
    @(negedge clk); #2;
    check("latency_valid", color_valid, 1);
    check("latency_data", color_data, 8'h02);
    wait_edge(n_edge + DB + 4);
    @(negedge clk); #2;
    check("latency_valid_drop", color_valid, 0);
    wait_edge(c0 + 12);
    btn[2] = 1'b0;
    tick(12);

    // 3: short green glitches are rejected, a long hold is accepted once.
    x0 = xfer_seen;
    for (int len = 1; len <= 3; len++) press(0, len, 8);
    check("glitch_no_transfer", xfer_seen - x0, 0);
    press(0, 8, 12);
    check("green_one_transfer", xfer_seen - x0, 1);
    check("green_data", last_data, 8'h00);

    // 4: green+yellow chord -> one error, no data; then blue accepted.
    x0 = xfer_seen; e0 = err_seen;
    btn = 4'b1001;
    tick(10);
    btn = '0;
    tick(12);
    check("chord_error_count", err_seen - e0, 1);
    check("chord_no_transfer", xfer_seen - x0, 0);
    press(1, 10, 12);
    check("blue_after_chord", last_data, 8'h01);

    // 5: full buffer -> overrun, buffered code kept, then drained.
    color_ready = 1'b0;
    o0 = ovr_seen;
    press(3, 10, 12);
    check("held_valid", color_valid, 1);
    check("held_data", color_data, 8'h03);
    press(0, 10, 12);
    check("overrun_count", ovr_seen - o0, 1);
    check("overrun_data_kept", color_data, 8'h03);
    color_ready = 1'b1;
    c0 = cyc;
    wait_edge(c0 + 1);
    @(negedge clk); #2;
    check("drain_valid_low", color_valid, 0);
    check("drain_data", last_data, 8'h03);
    tick(2);

    // 6: red pressed while blue is still held -> ignored, no error.
    x0 = xfer_seen; e0 = err_seen;
    btn[1] = 1'b1;
    tick(10);
    btn[2] = 1'b1;
    tick(10);
    btn[2] = 1'b0;
    tick(10);
    btn[1] = 1'b0;
    tick(12);
    check("wait_release_transfers", xfer_seen - x0, 1);
    check("wait_release_data", last_data, 8'h01);
    check("wait_release_no_error", err_seen - e0, 0);

    // 1b: reset mid-run with a press pending; red held through reset is
    // debounced afresh and gives exactly one press.
    color_ready = 1'b0;
    btn[2] = 1'b1;
    tick(10);
    check("pre_reset_valid", color_valid, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midrun_reset");
    tick(2);
    rst_n = 1'b1;
    color_ready = 1'b1;
    x0 = xfer_seen;
    tick(12);
    btn[2] = 1'b0;
    tick(12);
    check("post_reset_transfers", xfer_seen - x0, 1);
    check("post_reset_data", last_data, 8'h02);

    // Randomized activity: single presses, chords, glitches, ready toggling.
    for (int it = 0; it < 200; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        btn = '0;
        btn[$urandom_range(0, 3)] = 1'b1;
      end else begin
        btn = 4'($urandom_range(0, 15));
      end
      color_ready = ($urandom_range(0, 3) != 0);
      tick($urandom_range(1, 12));
      if ($urandom_range(0, 2) == 0) begin
        btn = '0;
        tick($urandom_range(1, 10));
      end
    end

    // Drain and make sure every predicted event was observed.
    btn = '0;
    color_ready = 1'b1;
    tick(30);
    check("xfer_queue_empty", xfer_q.size(), 0);
    check("error_queue_empty", err_q.size(), 0);
    check("overrun_queue_empty", ovr_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
